// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register for the 3-bit-register MIPS core. It also
//   detects load-use hazards and keeps a saturating count of the bubbles
//   inserted for them.
//
//   Each cycle the register does one of the following:
//     - captures the decode slot,
//     - loads a bubble, on a branch flush or a load-use hazard, or
//     - holds its contents while a multi-cycle EX op is busy.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   id_*               decoded instruction from the IF/ID side
//   flush              taken branch/jump: kill the decode instruction
//   ex_busy            multi-cycle EX op in progress: hold this register
//   stall_out          combinational freeze request for the PC and IF/ID
//   ex_*               registered instruction presented to execute/forwarding
//   bubble_cnt         saturating count of load-use bubbles
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rsrc1,
    input  logic [REG_W-1:0]  id_rsrc2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_W-1:0]  id_rdst,
    input  logic [DATA_W-1:0] id_op1,
    input  logic [DATA_W-1:0] id_op2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_alu_op,
    input  logic              id_wb_en,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              flush,
    input  logic              ex_busy,
    output logic              stall_out,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic [REG_W-1:0]  ex_rsrc1,
    output logic [REG_W-1:0]  ex_rsrc2,
    output logic [REG_W-1:0]  ex_rdst,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_alu_op,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
        logic [3:0]        alu_op;
        logic [REG_W-1:0]  rsrc1;
        logic [REG_W-1:0]  rsrc2;
        logic [REG_W-1:0]  rdst;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] imm;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t id_d;
    logic    hazard;

    // A load in EX whose result the decode instruction reads. R0 is an
    // ordinary register here, so an r0 match still counts as a hazard.
    assign hazard = ex_q.valid & ex_q.mem_rd & ex_q.wb_en & id_valid &
                    ((id_use1 & (id_rsrc1 == ex_q.rdst)) |
                     (id_use2 & (id_rsrc2 == ex_q.rdst)));

    // Flush kills the decode instruction, so freezing fetch would be wrong.
    assign stall_out = ~flush & (hazard | ex_busy);

    // An invalid decode slot is still captured, but it must never write
    // the register file or memory.
    always_comb begin
        id_d        = '0;
        id_d.valid  = id_valid;
        id_d.wb_en  = id_wb_en & id_valid;
        id_d.mem_rd = id_mem_rd & id_valid;
        id_d.mem_wr = id_mem_wr & id_valid;
        id_d.alu_op = id_alu_op;
        id_d.rsrc1  = id_rsrc1;
        id_d.rsrc2  = id_rsrc2;
        id_d.rdst   = id_rdst;
        id_d.op1    = id_op1;
        id_d.op2    = id_op2;
        id_d.imm    = id_imm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (ex_busy) begin
            ex_q <= ex_q;
        end else if (hazard) begin
            ex_q <= '0;
            if (bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + 1'b1;
        end else begin
            ex_q <= id_d;
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_wb_en  = ex_q.wb_en;
    assign ex_mem_rd = ex_q.mem_rd;
    assign ex_mem_wr = ex_q.mem_wr;
    assign ex_alu_op = ex_q.alu_op;
    assign ex_rsrc1  = ex_q.rsrc1;
    assign ex_rsrc2  = ex_q.rsrc2;
    assign ex_rdst   = ex_q.rdst;
    assign ex_op1    = ex_q.op1;
    assign ex_op2    = ex_q.op2;
    assign ex_imm    = ex_q.imm;

endmodule
